// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, frame length and baud divisor helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int FRAME_BITS = 10;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with show-ahead read data; push when full and pop when empty are ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_fifo_top.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding an LSB-first serialiser.
//
//   state | meaning
//   IDLE  | line high, waiting for the FIFO to hold a byte
//   START | start bit (low) for one bit period
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit (high); chains straight into START if more data is queued
module uart_tx_fifo_top
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CW  = $clog2(CPB) + 1;

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          pop;
  logic          bit_end;
  logic [7:0]    fifo_rdata;
  logic          fifo_full, fifo_empty;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_valid && tx_ready),
    .wdata_i (tx_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign tx_ready = !fifo_full;
  assign busy     = (state_q != IDLE) || !fifo_empty;
  assign tx       = tx_q;
  assign bit_end  = (cnt_q == CW'(CPB - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;

    // Per-bit period counter restarts at every boundary, so no drift accumulates.
    if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + CW'(1);

    case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          bit_d   = '0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            bit_d   = '0;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_top.sv
// Bench for uart_tx_fifo_top at 10 clocks per bit: line receiver model plus expected-byte queue.
module tb_uart_tx_fifo_top;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic [4:0] fifo_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  int         starts_q[$];
  bit         rx_active = 1'b0;

  uart_tx_fifo_top #(
    .CLK_FREQ   (1_000_000),
    .BAUD_RATE  (100_000),
    .FIFO_DEPTH (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Receiver model: start detected at the first low sample, bits sampled mid-period.
  initial begin : monitor
    int         rx_t;
    int         cyc;
    logic [7:0] rx_byte;
    logic       rx_start;
    logic [7:0] e;
    cyc = 0;
    rx_t = 0;
    rx_byte = 8'h00;
    rx_start = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        rx_active = 1'b0;
      end else if (!rx_active) begin
        if (tx === 1'b0) begin
          rx_active = 1'b1;
          rx_t = 0;
          starts_q.push_back(cyc);
        end
      end else begin
        rx_t++;
        if (rx_t == 5) begin
          rx_start = tx;
        end else if (rx_t > 5 && rx_t < 95 && (rx_t % 10) == 5) begin
          rx_byte = {tx, rx_byte[7:1]};
        end else if (rx_t == 95) begin
          rx_active = 1'b0;
          check("rx framing start/stop", {30'd0, rx_start, tx}, 32'h1);
          if (exp_q.size() == 0) begin
            check("rx unexpected byte", 32'(rx_byte), 32'h100);
          end else begin
            e = exp_q.pop_front();
            check("rx byte", 32'(rx_byte), 32'(e));
          end
        end
      end
    end
  end

  task automatic push(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    check("push ready", 32'(tx_ready), 32'h1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    exp_q.push_back(b);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || rx_active) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({name, " idle within budget"}, 32'(n < 5000), 32'h1);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [9:0] frame;
    logic [7:0] d;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset tx", 32'(tx), 32'h1);
    check("reset tx_ready", 32'(tx_ready), 32'h1);
    check("reset busy", 32'(busy), 32'h0);
    check("reset fifo_count", 32'(fifo_count), 32'h0);
    @(posedge clk);
    #1;

    // Single byte 0x55: full waveform check, cycle by cycle.
    push(8'h55);
    @(negedge clk);
    check("single tx before E1", 32'(tx), 32'h1);
    check("single count before E1", 32'(fifo_count), 32'h1);
    frame = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      check("single tx waveform", 32'(tx), 32'(frame[k / 10]));
      check("single busy in frame", 32'(busy), 32'h1);
    end
    @(negedge clk);
    check("single busy after 100", 32'(busy), 32'h0);
    check("single count after", 32'(fifo_count), 32'h0);
    check("single tx idle", 32'(tx), 32'h1);
    wait_idle("single");

    // Back-to-back frames with no idle gap.
    starts_q.delete();
    push(8'hA3);
    push(8'h0F);
    wait_idle("b2b");
    check("b2b frame count", 32'(starts_q.size()), 32'd2);
    if (starts_q.size() == 2)
      check("b2b start spacing", 32'(starts_q[1] - starts_q[0]), 32'd100);

    // Burst: 20 offered, 17 accepted (one popped by the FSM, then 16 fill the FIFO).
    for (int i = 0; i < 20; i++) begin
      tx_data  = 8'(i);
      tx_valid = 1'b1;
      @(negedge clk);
      check("burst tx_ready", 32'(tx_ready), 32'(i < 17));
      if (i == 17) check("burst full count", 32'(fifo_count), 32'd16);
      if (i < 17) exp_q.push_back(8'(i));
      @(posedge clk);
      #1;
    end
    tx_valid = 1'b0;
    wait_idle("burst");

    // Reset in the middle of the first frame discards everything.
    push(8'hFF);
    push(8'h00);
    repeat (34) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst tx", 32'(tx), 32'h1);
    check("midrst fifo_count", 32'(fifo_count), 32'h0);
    check("midrst tx_ready", 32'(tx_ready), 32'h1);
    check("midrst busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    push(8'h3C);
    wait_idle("post-reset");

    // Backpressure: fill, toggle data while blocked, first accept after the first pop.
    for (int j = 1; j <= 103; j++) begin
      d = (j <= 17) ? 8'(8'h40 + j - 1) : (8'(j) ^ 8'hA5);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      check("bp tx_ready", 32'(tx_ready), 32'(j <= 17 || j == 103));
      if (j > 17 && j < 103) check("bp count held", 32'(fifo_count), 32'd16);
      if (j <= 17 || j == 103) exp_q.push_back(d);
      @(posedge clk);
      #1;
    end
    tx_valid = 1'b0;
    wait_idle("backpressure");

    // Push lands exactly on the final STOP cycle while one byte is queued.
    starts_q.delete();
    push(8'h81);
    push(8'h42);
    repeat (99) @(posedge clk);
    #1;
    tx_data  = 8'hE7;
    tx_valid = 1'b1;
    @(negedge clk);
    check("simul count before", 32'(fifo_count), 32'd1);
    check("simul tx before", 32'(tx), 32'h1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    exp_q.push_back(8'hE7);
    @(negedge clk);
    check("simul count after", 32'(fifo_count), 32'd1);
    check("simul next start", 32'(tx), 32'h0);
    wait_idle("simul");
    check("simul frame count", 32'(starts_q.size()), 32'd3);
    if (starts_q.size() == 3) begin
      check("simul spacing 1", 32'(starts_q[1] - starts_q[0]), 32'd100);
      check("simul spacing 2", 32'(starts_q[2] - starts_q[1]), 32'd100);
    end

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
